seq_detect_param: RTL

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_detect_pkg.sv | 21 ++
 rtl/seq_shift_fill.sv | 54 +++++
 rtl/seq_detect_param.sv | 108 ++++++++++
 3 files changed

// File: rtl/seq_detect_pkg.sv
// ---------------------------------------------------------------------------
// seq_detect_pkg
//   Shared types and constants for the parameterised serial sequence
//   detector (seq_detect_param) and its shift/fill datapath (seq_shift_fill).
//   Contents:
//     state_t    - detector FSM state (FILL, ARMED, HIT)
//     PAT_W_MIN  - smallest supported pattern length
//     PAT_W_MAX  - largest supported pattern length
// ---------------------------------------------------------------------------
package seq_detect_pkg;

   localparam int PAT_W_MIN = 2;
   localparam int PAT_W_MAX = 16;

   typedef enum logic [1:0] {
      FILL  = 2'd0,   // fewer than PAT_W valid bits collected
      ARMED = 2'd1,   // history full, last edge produced no match
      HIT   = 2'd2    // last edge completed the pattern, Dout=1
   } state_t;

endpackage

// File: rtl/seq_shift_fill.sv
// ---------------------------------------------------------------------------
// seq_shift_fill
//   Serial history shift register plus saturating fill counter.
//   The "next" values are exported combinationally so the parent can decide
//   on a match in the same edge that samples the completing bit.
// Ports:
//   clk       in   clock, rising edge
//   reset     in   synchronous active-high reset (clears hist and fill)
//   din_valid in   sample din on this edge
//   din       in   serial data bit, shifted in at the LSB
//   fill_clr  in   force fill to 0 on this edge (non-overlapping restart)
//   hist_nxt  out  history as it will be after this edge
//   fill_nxt  out  fill count as it will be after this edge, before fill_clr
// ---------------------------------------------------------------------------
module seq_shift_fill #(
   parameter int PAT_W  = 4,
   parameter int FILL_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              din_valid,
   input  logic              din,
   input  logic              fill_clr,
   output logic [PAT_W-1:0]  hist_nxt,
   output logic [FILL_W-1:0] fill_nxt
);

   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

   logic [PAT_W-1:0]  hist;
   logic [FILL_W-1:0] fill;

   always_comb begin
      hist_nxt = hist;
      fill_nxt = fill;
      if (din_valid) begin
         hist_nxt = {hist[PAT_W-2:0], din};
         if (fill != FILL_FULL) begin
            fill_nxt = fill + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hist <= '0;
         fill <= '0;
      end else begin
         hist <= hist_nxt;
         fill <= fill_clr ? '0 : fill_nxt;
      end
   end

endmodule

// File: rtl/seq_detect_param.sv
// ---------------------------------------------------------------------------
// seq_detect_param
//   Parameterised serial sequence detector. Bits arrive on Din when
//   din_valid=1; when the last PAT_W valid bits equal PATTERN (MSB = oldest)
//   Dout pulses high for one cycle, one cycle after the completing edge.
//   OVERLAP=1 lets consecutive matches share bits; OVERLAP=0 requires PAT_W
//   fresh valid bits after each match.
//   Optional feature: define SEQ_MATCH_CNT_EN to add a saturating match
//   counter on port match_cnt.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset, wins over din_valid
//   din_valid  in   Din is sampled only when 1
//   Din        in   serial data bit
//   Dout       out  registered match pulse (Moore, from FSM state HIT)
//   fsm_state  out  current FSM state, for observation
//   match_cnt  out  saturating match count (SEQ_MATCH_CNT_EN only)
// ---------------------------------------------------------------------------
module seq_detect_param
   import seq_detect_pkg::*;
#(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = 4'b0110,
   parameter int               OVERLAP = 1,
   parameter int               CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             din_valid,
   input  logic             Din,
   output logic             Dout,
   output state_t           fsm_state
`ifdef SEQ_MATCH_CNT_EN
   ,
   output logic [CNT_W-1:0] match_cnt
`endif
);

   localparam int                FILL_W    = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

   generate
      if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
         $error("seq_detect_param: PAT_W out of supported range");
      end
   endgenerate

   logic [PAT_W-1:0]  hist_nxt;
   logic [FILL_W-1:0] fill_nxt;
   logic              full_nxt;
   logic              match;
   logic              fill_clr;
   state_t            state;
   state_t            state_nxt;

   // A match needs a real sample on this edge; a held history that already
   // equals PATTERN does not count again.
   assign full_nxt = (fill_nxt == FILL_FULL);
   assign match    = din_valid && (hist_nxt == PATTERN) && full_nxt;
   assign fill_clr = match && (OVERLAP == 0);

   seq_shift_fill #(
      .PAT_W  (PAT_W),
      .FILL_W (FILL_W)
   ) u_shift_fill (
      .clk       (clk),
      .reset     (reset),
      .din_valid (din_valid),
      .din       (Din),
      .fill_clr  (fill_clr),
      .hist_nxt  (hist_nxt),
      .fill_nxt  (fill_nxt)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FILL;
      end else begin
         state <= state_nxt;
      end
   end

   // Leaving HIT: full_nxt is still set with OVERLAP=1 (fill stayed at
   // PAT_W), but clear with OVERLAP=0 because fill restarted from 0.
   always_comb begin
      state_nxt = state;
      case (state)
         FILL:    state_nxt = match ? HIT : (full_nxt ? ARMED : FILL);
         ARMED:   state_nxt = match ? HIT : ARMED;
         HIT:     state_nxt = match ? HIT : (full_nxt ? ARMED : FILL);
         default: state_nxt = FILL;
      endcase
   end

   assign Dout      = (state == HIT);
   assign fsm_state = state;

`ifdef SEQ_MATCH_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         match_cnt <= '0;
      end else if (match && (match_cnt != {CNT_W{1'b1}})) begin
         match_cnt <= match_cnt + 1'b1;
      end
   end
`endif

endmodule
